regfile_write_buffer: RTL and testbench

Write-side companion to the 32x32 register file: a small in-order FIFO that accepts retired results (destination register plus data) through a valid/ready handshake. It drains them one per cycle into the register file's single write port (write enable, write address, write data). While entries are pending, it supplies youngest-wins forwarding for the two decode read ports, so readers never observe a stale value. It sits between the writeback stage and the register file.

---
 rtl/regfile_write_buffer.sv | 82 ++++++++
 tb/tb_regfile_write_buffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer: in-order retire FIFO that drains into the register file write port
// and forwards the youngest pending value to the two decode read ports.
module regfile_write_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_rd,
    input  logic [XLEN-1:0]            in_data,
    input  logic                       drain_stall,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    input  logic [AW-1:0]              rs1,
    input  logic [AW-1:0]              rs2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [XLEN-1:0]            fwd1,
    output logic [XLEN-1:0]            fwd2,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]   r_rd   [DEPTH];
    logic [XLEN-1:0] r_data [DEPTH];
    logic [PW-1:0]   r_head, r_tail;
    logic [CW-1:0]   r_count;
    logic            w_push;

    assign empty    = r_count == '0;
    assign full     = r_count == CW'(DEPTH);
    assign in_ready = !full;
    assign count    = r_count;
    assign rf_we    = !empty && !drain_stall;
    assign rf_waddr = empty ? '0 : r_rd[r_head];
    assign rf_wdata = empty ? '0 : r_data[r_head];
    // x0 results complete the handshake but are never stored
    assign w_push   = in_valid && in_ready && in_rd != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (rf_we) r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(rf_we);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_tail]   <= in_rd;
            r_data[r_tail] <= in_data;
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest
    function automatic logic [XLEN:0] lookup(input logic [AW-1:0] rs);
        logic [XLEN:0] res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if (CW'(i) < r_count && rs != '0 && r_rd[idx] == rs) res = {1'b1, r_data[idx]};
        end
        return res;
    endfunction

    always_comb begin
        {hit1, fwd1} = lookup(rs1);
        {hit2, fwd2} = lookup(rs2);
    end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// tb_regfile_write_buffer: directed steps with a write-order scoreboard checked on every drain.
module tb_regfile_write_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_data = '0;
    logic        drain_stall = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        hit1, hit2;
    logic [31:0] fwd1, fwd2;
    logic [2:0]  count;
    logic        empty, full;

    int total = 0;
    int bad = 0;
    logic [36:0] q[$];

    regfile_write_buffer #(.DEPTH(4), .XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .drain_stall(drain_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rs1(rs1), .rs2(rs2), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] rd, input logic [31:0] d);
        in_valid = 1'b1;
        in_rd = rd;
        in_data = d;
        if (rd != 0) q.push_back({rd, d});
    endtask

    // Every register-file write must be the oldest outstanding expected write
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            logic [36:0] e;
            if (q.size() == 0) begin
                chk("unexpected_write", {27'd0, rf_waddr}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("drain_rd", {27'd0, rf_waddr}, {27'd0, e[36:32]});
                chk("drain_data", rf_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_hits", {hit1, hit2}, 0);
        chk("rst_fwd", fwd1 | fwd2, 0);
        step();
        rst = 1'b0;

        // single write
        offer(5, 32'hDEAD_BEEF);
        step();
        in_valid = 1'b0;
        chk("single_we", rf_we, 1);
        chk("single_waddr", rf_waddr, 5);
        chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);
        chk("single_count", count, 1);
        step();
        chk("single_count0", count, 0);
        chk("single_empty", empty, 1);
        chk("single_we0", rf_we, 0);

        // fill and backpressure
        drain_stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(5'(i), 32'(i * 16));
            step();
        end
        chk("fill_full", full, 1);
        chk("fill_ready", in_ready, 0);
        chk("fill_count", count, 4);
        chk("stall_we", rf_we, 0);
        offer(6, 32'h60);
        step();
        chk("full_reject_count", count, 4);
        drain_stall = 1'b0;
        #1;
        chk("drain_head1", rf_waddr, 1);
        step();
        chk("after_full_count", count, 3);
        chk("after_full_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("push_pop_count", count, 3);
        chk("drain_head3", rf_waddr, 3);
        step();
        step();
        chk("drain_head6", rf_waddr, 6);
        step();
        chk("fill_drained", empty, 1);

        // forwarding
        drain_stall = 1'b1;
        offer(3, 32'h11); step();
        offer(3, 32'h22); step();
        offer(7, 32'h33); step();
        in_valid = 1'b0;
        in_rd = 9;
        in_data = 32'h99;
        rs1 = 3;
        rs2 = 7;
        #1;
        chk("fwd_hit1", hit1, 1);
        chk("fwd_data1_youngest", fwd1, 32'h22);
        chk("fwd_hit2", hit2, 1);
        chk("fwd_data2", fwd2, 32'h33);
        rs2 = 0;
        #1;
        chk("fwd_x0_hit", hit2, 0);
        chk("fwd_x0_data", fwd2, 0);
        rs2 = 9;
        #1;
        chk("fwd_in_data_not_searched", hit2, 0);
        drain_stall = 1'b0;
        step();
        chk("fwd_after_pop_hit", hit1, 1);
        chk("fwd_after_pop_data", fwd1, 32'h22);
        step();
        chk("fwd_gone_hit", hit1, 0);
        chk("fwd_gone_data", fwd1, 0);
        step();
        chk("fwd_empty", empty, 1);
        chk("fwd_empty_hits", {hit1, hit2}, 0);

        // x0 discard
        offer(0, 32'hFFFF_FFFF);
        chk("x0_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("x0_count", count, 0);
        step();
        chk("x0_empty", empty, 1);

        // sustained push+pop wrapping the pointers
        drain_stall = 1'b1;
        offer(8, $urandom); step();
        offer(9, $urandom); step();
        drain_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            offer(5'(10 + i), $urandom);
            step();
            chk("concurrent_count", count, 2);
        end
        drain_stall = 1'b1;
        offer(20, $urandom);
        step();
        in_valid = 1'b0;
        chk("pending3", count, 3);
        rs1 = 20;
        #1;
        chk("pre_rst_hit", hit1, 1);

        // asynchronous reset mid-drain
        drain_stall = 1'b0;
        #1;
        rst = 1'b1;
        q.delete();
        #1;
        chk("async_rf_we", rf_we, 0);
        chk("async_empty", empty, 1);
        chk("async_count", count, 0);
        chk("async_ready", in_ready, 1);
        chk("async_hit", hit1, 0);
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_empty", empty, 1);
        step();
        step();
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
